bit_population_generator: RTL and testbench

//   Counterpart of bit_population_counter: takes a population count N and emits, one beat per

---
 rtl/bit_pop_pkg.sv | 23 ++
 rtl/bit_population_generator_combination_next.sv | 37 +++
 rtl/bit_population_generator.sv | 101 ++++++++++
 tb/tb_bit_population_generator.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_pop_pkg.sv
// Shared types and helpers for the bit population generator: FSM states and
// the first/last word of a fixed-popcount sequence.
package bit_pop_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int CNT_W     = $clog2(DEF_WIDTH) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Smallest word with n bits set: the n low bits.
    function automatic logic [31:0] first_word(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction

    // Largest w-bit word with n bits set: the n high bits.
    function automatic logic [31:0] last_word(input int unsigned n, input int unsigned w);
        return first_word(n) << (w - n);
    endfunction

endpackage

// File: rtl/bit_population_generator_combination_next.sv
// Combinational successor of x among words with the same popcount (Gosper's hack).
// Arithmetic runs one bit wider than the word so the carry out of the top bit is kept.
module combination_next #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x_i,
    output logic [WIDTH-1:0] next_o
);

    localparam int CTZ_W = $clog2(WIDTH + 1);

    logic [WIDTH:0]   w_x;
    logic [WIDTH:0]   w_c;
    logic [WIDTH:0]   w_r;
    logic [WIDTH:0]   w_d;
    logic [CTZ_W-1:0] w_ctz;
    logic [WIDTH-1:0] w_spread;

    assign w_x = {1'b0, x_i};
    assign w_c = w_x & (-w_x);
    assign w_r = w_x + w_c;
    assign w_d = w_r ^ w_x;

    // w_c is one-hot, so scanning down leaves the index of its single set bit.
    always_comb begin
        w_ctz = '0;
        for (int i = WIDTH; i >= 0; i--) begin
            if (w_c[i]) begin
                w_ctz = CTZ_W'(i);
            end
        end
    end

    assign w_spread = WIDTH'((w_d >> 2) >> w_ctz);
    assign next_o   = w_r[WIDTH-1:0] | w_spread;

endmodule

// File: rtl/bit_population_generator.sv
// Enumerates every WIDTH-bit word with a requested popcount, ascending, one word per
// valid/ready handshake; the final word of each sequence is flagged with data_last_o.
//
// state | meaning
// IDLE  | waiting for a count; count_ready_o high, no data beat
// RUN   | presenting data_o; advances on each data handshake, leaves after the last
module bit_population_generator
    import bit_pop_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   srst_i,
    input  logic [$clog2(WIDTH):0] count_i,
    input  logic                   count_val_i,
    output logic                   count_ready_o,
    output logic [WIDTH-1:0]       data_o,
    output logic                   data_val_o,
    output logic                   data_last_o,
    input  logic                   data_ready_i,
    output logic                   err_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           r_state;
    logic [CW-1:0]    r_n;
    logic [WIDTH-1:0] r_data;
    logic             r_val;
    logic             r_last;
    logic             r_err;

    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_first;
    logic [WIDTH-1:0] w_first_last;
    logic [WIDTH-1:0] w_run_last;
    logic             w_count_bad;
    logic             w_fire;

    combination_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .x_i    (r_data),
        .next_o (w_next)
    );

    assign w_count_bad  = 32'(count_i) > WIDTH;
    assign w_fire       = r_val && data_ready_i;
    assign w_first      = WIDTH'(first_word(32'(count_i)));
    assign w_first_last = WIDTH'(last_word(32'(count_i), WIDTH));
    assign w_run_last   = WIDTH'(last_word(32'(r_n), WIDTH));

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            r_state <= IDLE;
            r_n     <= '0;
            r_data  <= '0;
            r_val   <= 1'b0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (count_val_i) begin
                        if (w_count_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_n     <= count_i;
                            r_data  <= w_first;
                            r_last  <= (w_first == w_first_last);
                            r_val   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_fire) begin
                        if (r_last) begin
                            r_state <= IDLE;
                            r_data  <= '0;
                            r_val   <= 1'b0;
                            r_last  <= 1'b0;
                        end else begin
                            r_data <= w_next;
                            r_last <= (w_next == w_run_last);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign count_ready_o = (r_state == IDLE);
    assign data_o        = r_data;
    assign data_val_o    = r_val;
    assign data_last_o   = r_last;
    assign err_o         = r_err;

endmodule

// File: tb/tb_bit_population_generator.sv
// Bench for bit_population_generator: a WIDTH=4 and a WIDTH=8 instance checked against
// a queue of expected words built by brute-force enumeration in ascending order.
module tb_bit_population_generator;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    logic [2:0] cnt4;
    logic       cval4, cready4, dval4, dlast4, dready4, err4;
    logic [3:0] data4;

    logic [3:0] cnt8;
    logic       cval8, cready8, dval8, dlast8, dready8, err8;
    logic [7:0] data8;

    beat_t q4[$];
    beat_t q8[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    bit_population_generator #(.WIDTH(4)) u_dut4 (
        .clk_i         (clk),
        .srst_i        (rst),
        .count_i       (cnt4),
        .count_val_i   (cval4),
        .count_ready_o (cready4),
        .data_o        (data4),
        .data_val_o    (dval4),
        .data_last_o   (dlast4),
        .data_ready_i  (dready4),
        .err_o         (err4)
    );

    bit_population_generator #(.WIDTH(8)) u_dut8 (
        .clk_i         (clk),
        .srst_i        (rst),
        .count_i       (cnt8),
        .count_val_i   (cval8),
        .count_ready_o (cready8),
        .data_o        (data8),
        .data_val_o    (dval8),
        .data_last_o   (dlast8),
        .data_ready_i  (dready8),
        .err_o         (err8)
    );

    task automatic push_exp(input int w, input int n);
        beat_t b;
        logic [7:0] v8;
        for (int v = 0; v < (1 << w); v++) begin
            v8 = 8'(v);
            if ($countones(v8) == n) begin
                b.data = v8;
                b.last = 1'b0;
                if (w == 4) q4.push_back(b);
                else        q8.push_back(b);
            end
        end
        if (w == 4) q4[q4.size()-1].last = 1'b1;
        else        q8[q8.size()-1].last = 1'b1;
    endtask

    task automatic drive_count4(input int n);
        @(negedge clk);
        cnt4  = 3'(n);
        cval4 = 1'b1;
        @(negedge clk);
        cval4 = 1'b0;
    endtask

    task automatic drive_count8(input int n);
        @(negedge clk);
        cnt8  = 4'(n);
        cval8 = 1'b1;
        @(negedge clk);
        cval8 = 1'b0;
    endtask

    // Called at a negedge; drains up to max_pops beats from q4, checking each handshake.
    task automatic consume4(input bit rnd, input int max_pops);
        beat_t      e;
        logic [3:0] held_d;
        logic       held_l;
        bit         held = 1'b0;
        int         pops = 0;
        int         cyc  = 0;
        while (q4.size() > 0 && pops < max_pops && cyc < 400) begin
            dready4 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (held) begin
                n_cmp++;
                if (dval4 !== 1'b1 || data4 !== held_d || dlast4 !== held_l) begin
                    n_bad++;
                    $display("FAIL hold4: got val=%b data=%b last=%b, need val=1 data=%b last=%b",
                             dval4, data4, dlast4, held_d, held_l);
                end
            end
            if (!rnd) begin
                n_cmp++;
                if (dval4 !== 1'b1) begin
                    n_bad++;
                    $display("FAIL gap4: got data_val=%b, need 1", dval4);
                end
            end
            held = 1'b0;
            if (dval4 === 1'b1 && dready4) begin
                e = q4.pop_front();
                pops++;
                n_cmp++;
                if (data4 !== e.data[3:0] || dlast4 !== e.last) begin
                    n_bad++;
                    $display("FAIL beat4: got data=%b last=%b, need data=%b last=%b",
                             data4, dlast4, e.data[3:0], e.last);
                end
            end else if (dval4 === 1'b1) begin
                held   = 1'b1;
                held_d = data4;
                held_l = dlast4;
            end
            @(negedge clk);
            cyc++;
        end
        dready4 = 1'b0;
        n_cmp++;
        if (q4.size() > 0 && pops < max_pops) begin
            n_bad++;
            $display("FAIL timeout4: got %0d beats, %0d still expected", pops, q4.size());
        end
    endtask

    task automatic check_idle4(input string tag);
        n_cmp++;
        if (dval4 !== 1'b0 || cready4 !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: got data_val=%b count_ready=%b, need 0 and 1", tag, dval4, cready4);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_cmp++;
        if (cready4 !== 1'b1 || dval4 !== 1'b0 || data4 !== 4'b0 || dlast4 !== 1'b0 || err4 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset4: got ready=%b val=%b data=%b last=%b err=%b, need 1 0 0000 0 0",
                     cready4, dval4, data4, dlast4, err4);
        end
        n_cmp++;
        if (cready8 !== 1'b1 || dval8 !== 1'b0 || data8 !== 8'b0 || dlast8 !== 1'b0 || err8 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset8: got ready=%b val=%b data=%h last=%b err=%b, need 1 0 00 0 0",
                     cready8, dval8, data8, dlast8, err8);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_seq_n2();
        push_exp(4, 2);
        drive_count4(2);
        consume4(1'b0, 1000);
        check_idle4("idle_after_n2");
    endtask

    task automatic test_single_beats();
        push_exp(4, 0);
        drive_count4(0);
        consume4(1'b0, 1000);
        check_idle4("idle_after_n0");
        push_exp(4, 4);
        drive_count4(4);
        consume4(1'b0, 1000);
        check_idle4("idle_after_n4");
    endtask

    task automatic test_error(input int n);
        drive_count4(n);
        n_cmp++;
        if (err4 !== 1'b1 || dval4 !== 1'b0 || cready4 !== 1'b1) begin
            n_bad++;
            $display("FAIL err_pulse n=%0d: got err=%b val=%b ready=%b, need 1 0 1", n, err4, dval4, cready4);
        end
        @(negedge clk);
        n_cmp++;
        if (err4 !== 1'b0 || dval4 !== 1'b0 || cready4 !== 1'b1) begin
            n_bad++;
            $display("FAIL err_once n=%0d: got err=%b val=%b ready=%b, need 0 0 1", n, err4, dval4, cready4);
        end
    endtask

    task automatic test_random_ready();
        push_exp(4, 1);
        drive_count4(1);
        consume4(1'b1, 1000);
        check_idle4("idle_after_rand");
    endtask

    task automatic test_reset_mid();
        push_exp(4, 2);
        drive_count4(2);
        consume4(1'b0, 3);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (dval4 !== 1'b0 || data4 !== 4'b0 || dlast4 !== 1'b0 || cready4 !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid: got val=%b data=%b last=%b ready=%b, need 0 0000 0 1",
                     dval4, data4, dlast4, cready4);
        end
        q4.delete();
        @(negedge clk);
        rst = 1'b0;
        push_exp(4, 1);
        drive_count4(1);
        consume4(1'b0, 1000);
        check_idle4("idle_after_reset_mid");
    endtask

    task automatic test_width8_all();
        int    exp_beats[9] = '{1, 8, 28, 56, 70, 56, 28, 8, 1};
        beat_t e;
        int    pops;
        int    cyc;
        for (int n = 0; n <= 8; n++) begin
            push_exp(8, n);
            drive_count8(n);
            pops = 0;
            cyc  = 0;
            dready8 = 1'b1;
            while (q8.size() > 0 && cyc < 200) begin
                if (dval8 === 1'b1) begin
                    e = q8.pop_front();
                    pops++;
                    n_cmp++;
                    if (data8 !== e.data || dlast8 !== e.last || $countones(data8) != n) begin
                        n_bad++;
                        $display("FAIL beat8 n=%0d: got data=%b last=%b, need data=%b last=%b",
                                 n, data8, dlast8, e.data, e.last);
                    end
                end else begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL gap8 n=%0d: got data_val=0 after %0d beats, need 1", n, pops);
                end
                @(negedge clk);
                cyc++;
            end
            dready8 = 1'b0;
            q8.delete();
            n_cmp++;
            if (pops != exp_beats[n]) begin
                n_bad++;
                $display("FAIL count8 n=%0d: got %0d beats, need %0d", n, pops, exp_beats[n]);
            end
            n_cmp++;
            if (dval8 !== 1'b0 || cready8 !== 1'b1) begin
                n_bad++;
                $display("FAIL idle8 n=%0d: got val=%b ready=%b, need 0 1", n, dval8, cready8);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        cnt4    = '0;
        cval4   = 1'b0;
        dready4 = 1'b0;
        cnt8    = '0;
        cval8   = 1'b0;
        dready8 = 1'b0;
        test_reset();
        test_seq_n2();
        test_single_beats();
        test_error(5);
        test_error(7);
        test_random_ready();
        test_reset_mid();
        test_width8_all();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
